// File: rtl/mem_access_ctrl.sv
// Multicycle LW/LH/LB/SW/SH/SB sequencer between the datapath and a single-port word memory.
// Build option: define MEM_ACCESS_SIGN_EXT_EN to sign-extend LH/LB results (zero-extend otherwise).
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] OP_LW    = 3'b000;
  localparam logic [2:0] OP_LH    = 3'b001;
  localparam logic [2:0] OP_LB    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b100;
  localparam logic [2:0] OP_SH    = 3'b101;
  localparam logic [2:0] OP_SB    = 3'b110;
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [31:0] wdata_r;
  logic [2:0]  cnt_r;
  logic [31:0] mdr_r;
  logic        err_flag_r;
  logic [31:0] mem_addr_r;
  logic        mem_wr_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] rdata_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [31:0] mdr_next_s;

  function automatic logic is_load(input logic [2:0] o);
    return (o == OP_LW) || (o == OP_LH) || (o == OP_LB);
  endfunction

  function automatic logic is_legal(input logic [2:0] o);
    return is_load(o) || (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h);
`ifdef MEM_ACCESS_SIGN_EXT_EN
    return {{16{h[15]}}, h};
`else
    return {16'h0000, h};
`endif
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] b);
`ifdef MEM_ACCESS_SIGN_EXT_EN
    return {{24{b[7]}}, b};
`else
    return {24'h000000, b};
`endif
  endfunction

  function automatic logic [31:0] load_result(input logic [2:0] o, input logic [31:0] w);
    logic [31:0] r;
    case (o)
      OP_LH:   r = ext_half(w[15:0]);
      OP_LB:   r = ext_byte(w[7:0]);
      default: r = w;
    endcase
    return r;
  endfunction

  // Lanes covered by the mask come from the store source, the rest from the fetched word.
  function automatic logic [31:0] merge_store(input logic [2:0] o, input logic [31:0] old_w,
                                              input logic [31:0] src);
    logic [31:0] mask;
    case (o)
      OP_SH:   mask = 32'h0000_FFFF;
      OP_SB:   mask = 32'h0000_00FF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_w & ~mask) | (src & mask);
  endfunction

  // Memory-data register capture: the read word is taken on the edge where the wait count hits 1.
  always_comb begin
    mdr_next_s = mdr_r;
    if ((state_r == ST_READ) && (cnt_r == 3'd1)) begin
      mdr_next_s = mem_rdata;
    end else begin
      mdr_next_s = mdr_r;
    end
  end

  // Sequencer FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      op_r        <= 3'b000;
      wdata_r     <= 32'h0000_0000;
      cnt_r       <= 3'd0;
      mdr_r       <= 32'h0000_0000;
      err_flag_r  <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wr_r    <= 1'b0;
      mem_wdata_r <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_wr_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      mdr_r    <= mdr_next_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op;
            wdata_r <= wdata;
            busy_r  <= 1'b1;
            if (!is_legal(op)) begin
              err_flag_r <= 1'b1;
              done_r     <= 1'b1;
              err_r      <= 1'b1;
              state_r    <= ST_DONE;
            end else if (op == OP_SW) begin
              err_flag_r  <= 1'b0;
              mem_addr_r  <= addr;
              mem_wdata_r <= wdata;
              mem_wr_r    <= 1'b1;
              state_r     <= ST_WRITE;
            end else begin
              err_flag_r <= 1'b0;
              mem_addr_r <= addr;
              cnt_r      <= LAT_INIT;
              state_r    <= ST_READ;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_READ: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            if (is_load(op_r)) begin
              rdata_r <= load_result(op_r, mdr_next_s);
              done_r  <= 1'b1;
              err_r   <= err_flag_r;
              state_r <= ST_DONE;
            end else begin
              mem_wdata_r <= merge_store(op_r, mdr_next_s, wdata_r);
              mem_wr_r    <= 1'b1;
              state_r     <= ST_WRITE;
            end
          end else begin
            state_r <= ST_READ;
          end
        end
        ST_WRITE: begin
          done_r  <= 1'b1;
          err_r   <= err_flag_r;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wr    = mem_wr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
